// File: rtl/mem_arb_pkg.sv
// Shared encodings for the instruction/data memory port arbiter.
package mem_arb_pkg;

    // Transaction sequencer states
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_RSP = 2'd2,
        ERR      = 2'd3
    } arb_state_e;

    // Which side owns the transaction currently on the memory port
    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_D  = 1'b1;

    // Fetches always read whole words; replicate this bit across the byte lanes
    localparam logic FETCH_BE_BIT = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_watchdog.sv
// Per-transaction cycle counter: cleared when a transaction starts, counts
// while it is outstanding, flags expiry on the cycle the limit is reached.
module arb_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_r;

    // Saturating cycle counter; clear takes priority over counting
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= '0;
        end else if (clr) begin
            cnt_r <= '0;
        end else if (en && (cnt_r != CW'(TIMEOUT))) begin
            cnt_r <= cnt_r + CW'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Expire while the increment on this edge would reach the limit
    assign expire = en && (cnt_r >= CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store.
// Data side has priority; a bounded burst counter lets a pending fetch in.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int MAX_D_BURST = 4,
    parameter int TIMEOUT     = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_req,
    input  logic [AW-1:0]   if_addr,
    output logic [DW-1:0]   if_rdata,
    output logic            if_valid,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [AW-1:0]   d_addr,
    input  logic [DW-1:0]   d_wdata,
    input  logic [DW/8-1:0] d_be,
    output logic [DW-1:0]   d_rdata,
    output logic            d_valid,
    output logic            mem_req,
    output logic            mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    output logic [DW/8-1:0] mem_be,
    input  logic            mem_gnt,
    input  logic            mem_rvalid,
    input  logic [DW-1:0]   mem_rdata,
    output logic            core_stall,
    output logic            bus_err
);

    localparam int BW  = DW / 8;
    localparam int BCW = $clog2(MAX_D_BURST + 1);

    arb_state_e     state_r;
    logic           owner_r;
    logic [BCW-1:0] burst_cnt_r;

    logic if_avail_s;
    logic d_avail_s;
    logic burst_full_s;
    logic grant_d_s;
    logic grant_if_s;
    logic complete_s;
    logic wd_en_s;
    logic wd_clr_s;
    logic wd_expire_s;

    // A source completing this cycle still holds its request; ignore it so
    // the finished request is not issued a second time.
    assign if_avail_s   = if_req & ~if_valid;
    assign d_avail_s    = d_req & ~d_valid;
    assign burst_full_s = (burst_cnt_r == BCW'(MAX_D_BURST));

    assign grant_d_s  = (state_r == IDLE) & d_avail_s & ~(burst_full_s & if_avail_s);
    assign grant_if_s = (state_r == IDLE) & if_avail_s & ~grant_d_s;

    // A response only counts once the request has been accepted
    assign complete_s = ((state_r == REQ) & mem_gnt & mem_rvalid)
                      | ((state_r == WAIT_RSP) & mem_rvalid);

    assign wd_clr_s = grant_d_s | grant_if_s;
    assign wd_en_s  = (state_r == REQ) | (state_r == WAIT_RSP);

    assign core_stall = (if_req & ~if_valid) | (d_req & ~d_valid) | bus_err;

    arb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .clr    (wd_clr_s),
        .en     (wd_en_s),
        .expire (wd_expire_s)
    );

    // Arbitration, transaction sequencing, response capture and error lock-up
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            owner_r     <= OWN_IF;
            burst_cnt_r <= '0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_be      <= '0;
            if_rdata    <= '0;
            d_rdata     <= '0;
            if_valid    <= 1'b0;
            d_valid     <= 1'b0;
            bus_err     <= 1'b0;
        end else begin
            if_valid <= 1'b0;
            d_valid  <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (grant_d_s) begin
                        owner_r     <= OWN_D;
                        mem_req     <= 1'b1;
                        mem_we      <= d_we;
                        mem_addr    <= d_addr;
                        mem_wdata   <= d_wdata;
                        mem_be      <= d_be;
                        burst_cnt_r <= if_avail_s ? (burst_cnt_r + BCW'(1)) : '0;
                        state_r     <= REQ;
                    end else if (grant_if_s) begin
                        owner_r     <= OWN_IF;
                        mem_req     <= 1'b1;
                        mem_we      <= 1'b0;
                        mem_addr    <= if_addr;
                        mem_wdata   <= '0;
                        mem_be      <= {BW{FETCH_BE_BIT}};
                        burst_cnt_r <= '0;
                        state_r     <= REQ;
                    end else begin
                        mem_req <= 1'b0;
                    end
                end
                REQ, WAIT_RSP: begin
                    if (complete_s) begin
                        mem_req <= 1'b0;
                        state_r <= IDLE;
                        if (owner_r == OWN_IF) begin
                            if_valid <= 1'b1;
                            if_rdata <= mem_rdata;
                        end else begin
                            d_valid <= 1'b1;
                            if (!mem_we) begin
                                d_rdata <= mem_rdata;
                            end else begin
                                d_rdata <= d_rdata;
                            end
                        end
                    end else if (wd_expire_s) begin
                        mem_req <= 1'b0;
                        bus_err <= 1'b1;
                        state_r <= ERR;
                    end else if ((state_r == REQ) && mem_gnt) begin
                        mem_req <= 1'b0;
                        state_r <= WAIT_RSP;
                    end else begin
                        mem_req <= (state_r == REQ);
                    end
                end
                ERR: begin
                    mem_req <= 1'b0;
                    bus_err <= 1'b1;
                end
                default: begin
                    mem_req <= 1'b0;
                    bus_err <= 1'b1;
                    state_r <= ERR;
                end
            endcase
        end
    end

endmodule
